// File: rtl/view_vector_sequencer.sv
// Builds forward/up/right view vectors from pitch and yaw using a shared sin/cos unit
// and a single time-shared 16x16 signed multiplier.
module view_vector_sequencer (
    input  logic        clk_100mhz,
    input  logic        rst_in,
    input  logic        start,
    input  logic [8:0]  pitch,
    input  logic [8:0]  yaw,
    output logic        trig_req,
    output logic [8:0]  trig_angle,
    output logic        trig_cos,
    input  logic        trig_ack,
    input  logic [15:0] trig_val,
    output logic        busy,
    output logic        done,
    output logic [15:0] x_fwd,
    output logic [15:0] y_fwd,
    output logic [15:0] z_fwd,
    output logic [15:0] x_up,
    output logic [15:0] y_up,
    output logic [15:0] z_up,
    output logic [15:0] x_right,
    output logic [15:0] y_right,
    output logic [15:0] z_right
);

    typedef enum logic [3:0] {
        IDLE, FETCH0, FETCH1, FETCH2, FETCH3, MUL0, MUL1, MUL2, MUL3, WRITE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [8:0]         pitch_lat;
    logic [8:0]         yaw_lat;
    logic signed [15:0] sp, cp, sy, cy;
    logic signed [15:0] prod_cpsy, prod_cpcy, prod_spsy, prod_spcy;
    logic signed [15:0] mul_a;
    logic signed [15:0] mul_b;
    logic signed [31:0] mul_full;

    // Q1.14 x Q1.14 -> Q1.14 by floor (arithmetic shift), no rounding or saturation.
    function automatic logic signed [15:0] q14_trunc(input logic signed [31:0] p);
        return $signed(p[29:14]);
    endfunction

    assign mul_full = mul_a * mul_b;

    always_ff @(posedge clk_100mhz or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        trig_req   = 1'b0;
        trig_angle = 9'd0;
        trig_cos   = 1'b0;
        mul_a      = cp;
        mul_b      = sy;
        case (state)
            IDLE:   if (start) state_next = FETCH0;
            FETCH0: begin
                trig_req   = 1'b1;
                trig_angle = pitch_lat;
                if (trig_ack) state_next = FETCH1;
            end
            FETCH1: begin
                trig_req   = 1'b1;
                trig_angle = pitch_lat;
                trig_cos   = 1'b1;
                if (trig_ack) state_next = FETCH2;
            end
            FETCH2: begin
                trig_req   = 1'b1;
                trig_angle = yaw_lat;
                if (trig_ack) state_next = FETCH3;
            end
            FETCH3: begin
                trig_req   = 1'b1;
                trig_angle = yaw_lat;
                trig_cos   = 1'b1;
                if (trig_ack) state_next = MUL0;
            end
            MUL0:   state_next = MUL1;
            MUL1: begin
                mul_b      = cy;
                state_next = MUL2;
            end
            MUL2: begin
                mul_a      = sp;
                state_next = MUL3;
            end
            MUL3: begin
                mul_a      = sp;
                mul_b      = cy;
                state_next = WRITE;
            end
            WRITE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_100mhz or posedge rst_in) begin
        if (rst_in) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            pitch_lat <= 9'd0;
            yaw_lat   <= 9'd0;
            sp        <= '0;
            cp        <= '0;
            sy        <= '0;
            cy        <= '0;
            prod_cpsy <= '0;
            prod_cpcy <= '0;
            prod_spsy <= '0;
            prod_spcy <= '0;
            x_fwd     <= '0;
            y_fwd     <= '0;
            z_fwd     <= '0;
            x_up      <= '0;
            y_up      <= '0;
            z_up      <= '0;
            x_right   <= '0;
            y_right   <= '0;
            z_right   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    pitch_lat <= pitch;
                    yaw_lat   <= yaw;
                    busy      <= 1'b1;
                end
                FETCH0: if (trig_ack) sp <= trig_val;
                FETCH1: if (trig_ack) cp <= trig_val;
                FETCH2: if (trig_ack) sy <= trig_val;
                FETCH3: if (trig_ack) cy <= trig_val;
                MUL0:   prod_cpsy <= q14_trunc(mul_full);
                MUL1:   prod_cpcy <= q14_trunc(mul_full);
                MUL2:   prod_spsy <= q14_trunc(mul_full);
                MUL3:   prod_spcy <= q14_trunc(mul_full);
                // All nine vector components change on the same edge.
                WRITE: begin
                    x_fwd   <= prod_cpsy;
                    y_fwd   <= -sp;
                    z_fwd   <= prod_cpcy;
                    x_up    <= prod_spsy;
                    y_up    <= cp;
                    z_up    <= prod_spcy;
                    x_right <= cy;
                    y_right <= 16'd0;
                    z_right <= -sy;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
